// File: rtl/phy_link_arbiter.sv
// Round-robin arbiter feeding NUM_REQ router requesters into one phy send path.
// Optional SEND dwell timeout is compiled in with macro PHY_LINK_TIMEOUT_EN.
module phy_link_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned IdW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [31:0]            phy_tx_data,
    output logic                   phy_enable_send,
    input  logic                   phy_tx_done,
    output logic [IdW-1:0]         grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]       grant_q, grant_d;
    logic [31:0]          data_q, data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;

    logic                 sel_found;
    logic [IdW-1:0]       sel_idx;
    logic [IdW-1:0]       cand;
    logic [IdW-1:0]       next_ptr;
    logic                 to_expire;

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IdW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign next_ptr = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef PHY_LINK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] to_cnt_q;
    logic            to_err_q;

    // Counter holds the number of SEND cycles already completed.
    assign to_expire = (state_q == StSend) && (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (state_q == StSend && state_d == StSend) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end else begin
                to_cnt_q <= '0;
            end
            if (to_expire && !phy_tx_done) begin
                to_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = to_err_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign to_expire             = 1'b0;
    assign timeout_err           = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        ack_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d = StSend;
                    grant_d = sel_idx;
                    data_d  = req_data[32*sel_idx +: 32];
                end
            end
            StSend: begin
                if (phy_tx_done) begin
                    ack_d[grant_q] = 1'b1;
                    rr_ptr_d       = next_ptr;
                    state_d        = StGap;
                end else if (to_expire) begin
                    rr_ptr_d = next_ptr;
                    state_d  = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
        end
    end

    assign req_ack         = ack_q;
    assign phy_tx_data     = data_q;
    assign grant_id        = grant_q;
    assign phy_enable_send = (state_q == StSend);
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_phy_link_arbiter.sv
// Directed plus randomized bench for phy_link_arbiter against a transaction-level
// round-robin model (next grant = first valid index at or after the pointer).
module tb_phy_link_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [32*N-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic [31:0]    phy_tx_data;
    logic           phy_enable_send;
    logic           phy_tx_done;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_err;

    int             errors = 0;
    int             checks = 0;
    int             m_ptr;
    logic [31:0]    words[N];

    phy_link_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ack         (req_ack),
        .phy_tx_data     (phy_tx_data),
        .phy_enable_send (phy_enable_send),
        .phy_tx_done     (phy_tx_done),
        .grant_id        (grant_id),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (ptr + i) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic load_words();
        for (int i = 0; i < N; i++) begin
            words[i]            = $urandom;
            req_data[32*i +: 32] = words[i];
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_en"}, 32'(phy_enable_send), 0);
        check({tag, "_ack"}, 32'(req_ack), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, phy_tx_data, 0);
        check({tag, "_en"}, 32'(phy_enable_send), 0);
        check({tag, "_ack"}, 32'(req_ack), 0);
        check({tag, "_grant"}, 32'(grant_id), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_terr"}, 32'(timeout_err), 0);
    endtask

    // One full word: grant, SEND of 'delay' cycles ending with phy_tx_done, GAP, IDLE.
    // Caller has loaded words[] / req_data beforehand.
    task automatic transfer(input logic [N-1:0] v, input int delay, input bit hold,
                            input bit gap_done);
        int          g;
        logic [31:0] w;
        logic [N-1:0] oh;
        g  = pick(m_ptr, v);
        w  = words[g];
        oh = 4'b0001 << g;
        req_valid = v;
        step();
        check("grant", 32'(grant_id), g);
        check("tx_data", phy_tx_data, w);
        check("send_en", 32'(phy_enable_send), 1);
        check("send_ack", 32'(req_ack), 0);
        if (!hold) req_valid = '0;
        load_words();
        for (int k = 1; k < delay; k++) begin
            step();
            check("hold_en", 32'(phy_enable_send), 1);
            check("hold_data", phy_tx_data, w);
            check("hold_grant", 32'(grant_id), g);
            check("hold_ack", 32'(req_ack), 0);
        end
        phy_tx_done = 1'b1;
        step();
        phy_tx_done = 1'b0;
        check("gap_en", 32'(phy_enable_send), 0);
        check("gap_ack", 32'(req_ack), 32'(oh));
        check("gap_busy", 32'(busy), 1);
        m_ptr = (g + 1) % N;
        phy_tx_done = gap_done;
        step();
        phy_tx_done = 1'b0;
        check_idle("post_gap");
        check("post_gap_grant", 32'(grant_id), g);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        phy_tx_done = 1'b0;
        m_ptr       = 0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single requester 2 with a fixed word.
        load_words();
        words[2]        = 32'hA5A5_0002;
        req_data[95:64] = words[2];
        transfer(4'b0100, 1, 1'b0, 1'b0);

        // Rotation from a freshly reset pointer with all requesters held valid.
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ptr = 0;
        for (int t = 0; t < 5; t++) begin
            load_words();
            transfer(4'b1111, 4, 1'b1, 1'b0);
        end
        req_valid = '0;

        // Pointer at 3 after granting 2, then wrap to 0.
        load_words();
        transfer(4'b0100, 2, 1'b0, 1'b0);
        load_words();
        transfer(4'b1001, 3, 1'b1, 1'b0);
        load_words();
        transfer(4'b1001, 1, 1'b0, 1'b1);

        // phy_tx_done in IDLE is ignored.
        phy_tx_done = 1'b1;
        step();
        phy_tx_done = 1'b0;
        check_idle("idle_done");

        // Reset in the second SEND cycle aborts silently.
        load_words();
        req_valid = 4'b0110;
        step();
        check("pre_rst_en", 32'(phy_enable_send), 1);
        step();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_send");
        m_ptr = 0;
        step();
        check_idle("after_rst");
        load_words();
        transfer(4'b0001, 2, 1'b0, 1'b0);
        load_words();
        transfer(4'b1111, 1, 1'b0, 1'b0);

`ifdef PHY_LINK_TIMEOUT_EN
        // Done in the terminal cycle wins over the timeout.
        load_words();
        transfer(4'b0010, TO, 1'b0, 1'b0);
        check("to_edge_terr", 32'(timeout_err), 0);
        begin
            int g;
            g = pick(m_ptr, 4'b0100);
            load_words();
            req_valid = 4'b0100;
            step();
            req_valid = '0;
            for (int k = 1; k < TO; k++) begin
                step();
                check("to_send_en", 32'(phy_enable_send), 1);
            end
            step();
            check("to_gap_en", 32'(phy_enable_send), 0);
            check("to_gap_ack", 32'(req_ack), 0);
            check("to_terr", 32'(timeout_err), 1);
            m_ptr = (g + 1) % N;
            step();
            check_idle("to_idle");
            check("to_sticky", 32'(timeout_err), 1);
        end
        load_words();
        transfer(4'b1111, 1, 1'b0, 1'b0);
        check("to_sticky2", 32'(timeout_err), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ptr = 0;
        check("to_rst_clear", 32'(timeout_err), 0);
`else
        // Without the timeout, SEND waits well beyond TIMEOUT_CYCLES.
        load_words();
        transfer(4'b0010, 3 * TO, 1'b0, 1'b0);
        check("no_to_terr", 32'(timeout_err), 0);
`endif

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] v;
            v = N'($urandom_range(1, 15));
            load_words();
            transfer(v, int'($urandom_range(1, 6)), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                req_valid   = '0;
                phy_tx_done = 1'($urandom);
                step();
                phy_tx_done = 1'b0;
                check_idle("rand_idle");
            end
        end
        check("final_terr", 32'(timeout_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phy_link_arbiter.md
PHY_LINK_ARBITER -- requirements
Module: phy_link_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of router requesters sharing one phy send path.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum SEND dwell in cycles.
REQ-003 The block SHALL have port clk  input  1  single clock for all logic.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  NUM_REQ  per-requester word pending.
REQ-006 The block SHALL have port req_data  input  32*NUM_REQ  flattened request words, with requester i at bits [32*i+31:32*i].
REQ-007 The block SHALL have port req_ack  output  NUM_REQ  one-cycle pulse when the phy completes requester i's word.
REQ-008 The block SHALL have port phy_tx_data  output  32  registered word presented to phy input_data_from_router.
REQ-009 The block SHALL have port phy_enable_send  output  1  drives phy enable_send.
REQ-010 The block SHALL have port phy_tx_done  input  1  one-cycle pulse from the phy when the current word has been fully transferred and acknowledged.
REQ-011 The block SHALL have port grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-012 The block SHALL have port busy  output  1  high in SEND and GAP.
REQ-013 The block SHALL have port timeout_err  output  1  sticky SEND-timeout flag.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEND and GAP.
REQ-015 In IDLE with any req_valid bit set, the block SHALL select the first set bit searching from rr_ptr upward, modulo NUM_REQ.
- On the same edge it SHALL register req_data[selected] into phy_tx_data and the index into grant_id, and enter SEND.
REQ-016 Latency SHALL be exactly 1 cycle: req_valid sampled at edge N gives phy_enable_send=1 after edge N.
REQ-017 In SEND, phy_enable_send SHALL be 1, and phy_tx_data and grant_id SHALL be held constant.
REQ-018 On phy_tx_done in SEND:
- req_ack[grant_id] SHALL pulse for exactly 1 cycle;
- rr_ptr SHALL become (grant_id+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0;
- the FSM SHALL enter GAP.
REQ-019 GAP SHALL last exactly 1 cycle with phy_enable_send=0, then return to IDLE, guaranteeing at least 1 deassert cycle between words.
REQ-020 phy_tx_done SHALL be ignored in IDLE and GAP.
REQ-021 A requester dropping req_valid during SEND SHALL NOT abort the transfer; the word completes and req_ack still pulses.
REQ-022 With a single requester continuously valid, it SHALL be re-granted every transfer; with all requesters valid, grants SHALL rotate 0,1,...,NUM_REQ-1,0.
REQ-023 req_ack SHALL be all-zero except in the cycle after a completing phy_tx_done.

Reset
REQ-024 While rst is sampled high, the block SHALL force state=IDLE, rr_ptr=0, and the timeout counter to 0.
- All outputs SHALL be 0: phy_tx_data, phy_enable_send, req_ack, grant_id, busy and timeout_err.
REQ-025 Reset asserted during SEND SHALL abort the word with no req_ack pulse; phy_enable_send SHALL be 0 after that edge.

Configuration
REQ-026 The SEND-timeout feature SHALL be compiled in only when macro PHY_LINK_TIMEOUT_EN is defined.
REQ-027 With PHY_LINK_TIMEOUT_EN defined:
- a counter SHALL increment each SEND cycle;
- when it reaches TIMEOUT_CYCLES without phy_tx_done, the block SHALL enter GAP with no req_ack, set timeout_err (sticky until rst), and advance rr_ptr past grant_id;
- a phy_tx_done in the terminal-count cycle SHALL take priority as a normal completion.
REQ-028 With PHY_LINK_TIMEOUT_EN undefined, SEND SHALL wait indefinitely for phy_tx_done, and timeout_err SHALL be constant 0.

Verification
REQ-029 Reset, then req_valid=4'b0100 and req_data[2]=32'hA5A5_0002 -> after one edge, phy_enable_send=1, phy_tx_data=32'hA5A5_0002, grant_id=2.
- Then phy_tx_done pulse -> req_ack=4'b0100 for 1 cycle, followed by 1 GAP cycle.
REQ-030 req_valid=4'b1111 held with phy_tx_done pulsed 4 cycles into each SEND -> grant_id sequence 0,1,2,3,0, with one req_ack pulse per grant.
REQ-031 rr_ptr=3 (last grant 2) and req_valid=4'b1001 -> grant 3, then wrap to grant 0.
REQ-032 rst asserted in the 2nd SEND cycle -> next cycle all outputs 0 and no req_ack; then req_valid=4'b0001 -> grant 0.
REQ-033 With PHY_LINK_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, phy_tx_done held 0 -> after 8 SEND cycles phy_enable_send=0, timeout_err=1, no ack.
- phy_tx_done in the 8th cycle instead -> normal ack and timeout_err=0.
REQ-034 phy_tx_done pulsed in IDLE and in GAP -> no req_ack and no state change.
